// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES block sequencer slice.
//   DES_BLOCK_W : width of a DES data block (64)
//   DES_KEY_W   : width of a DES key including parity bits (64)
//   seq_state_t : sequencer state encoding
// ---------------------------------------------------------------------------
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_KEY_W   = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/des_block_sequencer_if.sv
// ---------------------------------------------------------------------------
// des_block_sequencer_if
// Block stream handshakes of the DES block sequencer.
//   in_data / in_valid / in_ready    : input block (producer -> sequencer)
//   out_data / out_valid / out_ready : result block (sequencer -> consumer)
// Modports:
//   master : the environment side (drives input block, accepts results)
//   slave  : the sequencer side
// ---------------------------------------------------------------------------
interface des_block_sequencer_if;
    import des_pkg::*;

    logic [DES_BLOCK_W-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [DES_BLOCK_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/des_chain_reg.sv
// ---------------------------------------------------------------------------
// des_chain_reg
// CBC chaining register with IV load and the pre/post XOR around the core.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset (chain cleared)
//   iv_load_en     : load iv_in into the chain register
//   iv_in          : IV value
//   update_en      : replace the chain with update_val (block completed)
//   update_val     : new chain value (ciphertext of the finished block)
//   pre_dir/pre_in : direction and block entering the core (0=encrypt)
//   pre_out        : encrypt: pre_in ^ chain, decrypt: pre_in
//   post_dir/post_in : direction and core result
//   post_out       : encrypt: post_in, decrypt: post_in ^ chain
// ---------------------------------------------------------------------------
module des_chain_reg
    import des_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iv_load_en,
    input  logic [DES_BLOCK_W-1:0] iv_in,
    input  logic                   update_en,
    input  logic [DES_BLOCK_W-1:0] update_val,
    input  logic                   pre_dir,
    input  logic [DES_BLOCK_W-1:0] pre_in,
    output logic [DES_BLOCK_W-1:0] pre_out,
    input  logic                   post_dir,
    input  logic [DES_BLOCK_W-1:0] post_in,
    output logic [DES_BLOCK_W-1:0] post_out
);

    logic [DES_BLOCK_W-1:0] chain_reg;

    // update_en and iv_load_en come from different sequencer states, so
    // they never coincide; the completed block still takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_reg <= '0;
        end else if (update_en) begin
            chain_reg <= update_val;
        end else if (iv_load_en) begin
            chain_reg <= iv_in;
        end
    end

    assign pre_out  = pre_dir  ? pre_in            : (pre_in ^ chain_reg);
    assign post_out = post_dir ? (post_in ^ chain_reg) : post_in;

endmodule

// File: rtl/des_block_sequencer.sv
// ---------------------------------------------------------------------------
// des_block_sequencer
// Feeds one 64-bit block at a time to an external DES core and returns the
// result, with a watchdog on the core's done response.
// Optional feature macro: DES_CBC_MODE_EN (CBC chaining; default is ECB).
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   key_in, dir            : key and direction (0=enc, 1=dec), taken at accept
//   iv_in, iv_load         : IV value and load strobe (CBC builds only)
//   bus                    : input/result block handshakes (slave modport)
//   core_start_encrypt/_decrypt : start levels to the core
//   core_key, core_text    : key and block presented to the core
//   core_done_encrypt/_decrypt, core_result : core completion and output
//   busy                   : a block is in flight
//   timeout_err            : sticky, core failed to answer in DONE_TIMEOUT
// ---------------------------------------------------------------------------
module des_block_sequencer
    import des_pkg::*;
#(
    parameter int DONE_TIMEOUT = 32
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DES_KEY_W-1:0]   key_in,
    input  logic                   dir,
    input  logic [DES_BLOCK_W-1:0] iv_in,
    input  logic                   iv_load,
    des_block_sequencer_if.slave   bus,
    output logic                   core_start_encrypt,
    output logic                   core_start_decrypt,
    output logic [DES_KEY_W-1:0]   core_key,
    output logic [DES_BLOCK_W-1:0] core_text,
    input  logic                   core_done_encrypt,
    input  logic                   core_done_decrypt,
    input  logic [DES_BLOCK_W-1:0] core_result,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    seq_state_t             state_reg;
    logic                   dir_reg;
    logic [DES_KEY_W-1:0]   key_reg;
    logic [DES_BLOCK_W-1:0] text_reg;
    logic [DES_BLOCK_W-1:0] out_data_reg;
    logic                   out_valid_reg;
    logic                   start_enc_reg;
    logic                   start_dec_reg;
    logic                   timeout_reg;
    logic                   discard_reg;
    logic [CNT_W-1:0]       cnt_reg;

    logic                   done_any;
    logic                   done_match;
    logic                   iv_block;
    logic                   accept;
    logic                   out_fire;
    logic [DES_BLOCK_W-1:0] pre_text;
    logic [DES_BLOCK_W-1:0] post_data;

    assign done_any   = core_done_encrypt | core_done_decrypt;
    // Only the done line of the running direction counts.
    assign done_match = dir_reg ? core_done_decrypt : core_done_encrypt;
    // A new block is refused while the core still reports done from the
    // previous one, so a stale done can never complete the next block.
    assign bus.in_ready = (state_reg == S_IDLE) && !iv_block && !done_any;
    assign accept       = bus.in_valid && bus.in_ready;
    assign out_fire     = (state_reg == S_OUT) && bus.out_ready;

`ifdef DES_CBC_MODE_EN
    logic [DES_BLOCK_W-1:0] chain_update_val;

    // Encrypt chains on the produced ciphertext, decrypt on the consumed one.
    assign chain_update_val = dir_reg ? text_reg : out_data_reg;
    assign iv_block         = iv_load;

    des_chain_reg u_chain (
        .clk        (clk),
        .rst_n      (rst_n),
        .iv_load_en (iv_load && (state_reg == S_IDLE)),
        .iv_in      (iv_in),
        .update_en  (out_fire),
        .update_val (chain_update_val),
        .pre_dir    (dir),
        .pre_in     (bus.in_data),
        .pre_out    (pre_text),
        .post_dir   (dir_reg),
        .post_in    (core_result),
        .post_out   (post_data)
    );
`else
    logic unused_iv;

    assign pre_text  = bus.in_data;
    assign post_data = core_result;
    assign iv_block  = 1'b0;
    assign unused_iv = ^{iv_in, iv_load};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            dir_reg       <= 1'b0;
            key_reg       <= '0;
            text_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            start_enc_reg <= 1'b0;
            start_dec_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            discard_reg   <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        key_reg       <= key_in;
                        dir_reg       <= dir;
                        text_reg      <= pre_text;
                        cnt_reg       <= '0;
                        start_enc_reg <= !dir;
                        start_dec_reg <= dir;
                        state_reg     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (done_match) begin
                        out_data_reg  <= post_data;
                        discard_reg   <= 1'b0;
                        start_enc_reg <= 1'b0;
                        start_dec_reg <= 1'b0;
                        state_reg     <= S_DRAIN;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Starts have now been held DONE_TIMEOUT cycles.
                        start_enc_reg <= 1'b0;
                        start_dec_reg <= 1'b0;
                        timeout_reg   <= 1'b1;
                        discard_reg   <= 1'b1;
                        state_reg     <= S_DRAIN;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (!done_any) begin
                        if (discard_reg) begin
                            state_reg <= S_IDLE;
                        end else begin
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.out_data       = out_data_reg;
    assign bus.out_valid      = out_valid_reg;
    assign core_start_encrypt = start_enc_reg;
    assign core_start_decrypt = start_dec_reg;
    assign core_key           = key_reg;
    assign core_text          = text_reg;
    assign busy               = (state_reg != S_IDLE);
    assign timeout_err        = timeout_reg;

endmodule

// File: tb/tb_des_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_des_block_sequencer
// Directed bench for des_block_sequencer. A behavioural DES core stand-in
// answers the standard test-vector pair exactly and uses an invertible XOR
// mapping for any other block. Build with DES_CBC_MODE_EN to exercise CBC.
// ---------------------------------------------------------------------------
module tb_des_block_sequencer;
    import des_pkg::*;

    localparam logic [63:0] K1   = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
    localparam logic [63:0] MASK = 64'hA5A5A5A5A5A5A5A5;
    localparam int          LAT  = 3;

    logic        clk;
    logic        rst_n;
    logic [63:0] key_in;
    logic        dir;
    logic [63:0] iv_in;
    logic        iv_load;
    logic        core_start_encrypt;
    logic        core_start_decrypt;
    logic [63:0] core_key;
    logic [63:0] core_text;
    logic        core_done_encrypt;
    logic        core_done_decrypt;
    logic [63:0] core_result;
    logic        busy;
    logic        timeout_err;

    des_block_sequencer_if bus ();

    des_block_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .key_in             (key_in),
        .dir                (dir),
        .iv_in              (iv_in),
        .iv_load            (iv_load),
        .bus                (bus),
        .core_start_encrypt (core_start_encrypt),
        .core_start_decrypt (core_start_decrypt),
        .core_key           (core_key),
        .core_text          (core_text),
        .core_done_encrypt  (core_done_encrypt),
        .core_done_decrypt  (core_done_decrypt),
        .core_result        (core_result),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DES core stand-in ----------------
    int          core_mode = 0;   // 0 normal, 1 never done, 2 wrong done first
    int          core_cnt  = 0;
    logic        m_done_e  = 1'b0;
    logic        m_done_d  = 1'b0;
    logic [63:0] m_res     = '0;
    logic        force_done_d = 1'b0;

    function automatic logic [63:0] des_model(input logic [63:0] k,
                                              input logic [63:0] t,
                                              input logic dec);
        if (k == K1 && !dec && t == PT1) return CT1;
        if (k == K1 && dec && t == CT1) return PT1;
        return t ^ k ^ MASK;
    endfunction

    always @(posedge clk) begin
        if (!(core_start_encrypt || core_start_decrypt)) begin
            core_cnt <= 0;
            m_done_e <= 1'b0;
            m_done_d <= 1'b0;
        end else begin
            core_cnt <= core_cnt + 1;
            if (core_mode == 0 && core_cnt == LAT) begin
                m_done_e <= core_start_encrypt;
                m_done_d <= core_start_decrypt;
                m_res    <= des_model(core_key, core_text, core_start_decrypt);
            end else if (core_mode == 2) begin
                if (core_cnt == LAT) begin
                    m_done_e <= core_start_decrypt;
                    m_done_d <= core_start_encrypt;
                    m_res    <= 64'hDEADBEEFDEADBEEF;
                end else if (core_cnt == LAT + 2) begin
                    m_done_e <= 1'b0;
                    m_done_d <= 1'b0;
                end else if (core_cnt == LAT + 4) begin
                    m_done_e <= core_start_encrypt;
                    m_done_d <= core_start_decrypt;
                    m_res    <= des_model(core_key, core_text, core_start_decrypt);
                end
            end
        end
    end

    assign core_done_encrypt = m_done_e;
    assign core_done_decrypt = m_done_d | force_done_d;
    assign core_result       = m_res;

    // ---------------- monitors ----------------
    int hs_count = 0;
    int ov_cycles = 0;
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) hs_count <= hs_count + 1;
        if (bus.out_valid) ov_cycles <= ov_cycles + 1;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [63:0] key;
        logic        dir;
        logic        ld_iv;
        logic [63:0] iv;
        logic [63:0] data;
        logic [63:0] exp_text;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string nm, input logic [63:0] k, input logic d,
                           input logic ld, input logic [63:0] iv,
                           input logic [63:0] data, input logic [63:0] et,
                           input logic [63:0] eo);
        vec_t v;
        v.name = nm; v.key = k; v.dir = d; v.ld_iv = ld; v.iv = iv;
        v.data = data; v.exp_text = et; v.exp_out = eo;
        vecs.push_back(v);
    endtask

    task automatic load_iv(input logic [63:0] v);
        @(negedge clk);
        iv_in   = v;
        iv_load = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
    endtask

    // Presents a block and returns at the first negedge after acceptance.
    task automatic send(input string nm, input logic [63:0] k, input logic d,
                        input logic [63:0] data);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_data  = data;
        key_in       = k;
        dir          = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int hs0;
        if (v.ld_iv) load_iv(v.iv);
        hs0 = hs_count;
        send(v.name, v.key, v.dir, v.data);
        chk({v.name, "_busy"}, 64'(busy), 64'd1);
        chk({v.name, "_starts"}, 64'({core_start_encrypt, core_start_decrypt}),
            64'({!v.dir, v.dir}));
        chk({v.name, "_core_key"}, core_key, v.key);
        chk({v.name, "_core_text"}, core_text, v.exp_text);
        wait_out(v.name);
        chk({v.name, "_out_data"}, bus.out_data, v.exp_out);
        $display("block %s: dir=%0d in=%h out=%h", v.name, v.dir, v.data, bus.out_data);
        ack();
        repeat (4) @(negedge clk);
        chk({v.name, "_one_handshake"}, 64'(hs_count - hs0), 64'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int ov0;
        logic [63:0] held;

        rst_n         = 1'b0;
        key_in        = '0;
        dir           = 1'b0;
        iv_in         = '0;
        iv_load       = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_starts", 64'({core_start_encrypt, core_start_decrypt}), 64'd0);
        chk("rst_timeout", 64'(timeout_err), 64'd0);
        chk("rst_core_text", core_text, 64'd0);
        chk("rst_core_key", core_key, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // in_ready must drop while the core still shows a done level.
        force_done_d = 1'b1;
        #1;
        chk("done_blocks_in_ready", 64'(bus.in_ready), 64'd0);
        force_done_d = 1'b0;
        #1;
        chk("done_release_in_ready", 64'(bus.in_ready), 64'd1);

`ifdef DES_CBC_MODE_EN
        add_vec("cbc_enc_iv", K1, 1'b0, 1'b1, PT1, 64'd0, PT1, CT1);
        add_vec("cbc_dec_iv", K1, 1'b1, 1'b1, PT1, CT1, CT1, 64'd0);
        add_vec("cbc_enc_chain", K1, 1'b0, 1'b0, 64'd0, CT1, 64'd0, 64'hB691F2DC3E197A54);
`else
        add_vec("ecb_enc_std", K1, 1'b0, 1'b0, 64'd0, PT1, PT1, CT1);
        add_vec("ecb_dec_std", K1, 1'b1, 1'b0, 64'd0, CT1, CT1, PT1);
        add_vec("ecb_enc_zero", 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, MASK);
        add_vec("ecb_enc_ones", '1, 1'b0, 1'b0, 64'd0, PT1, PT1, 64'h5B791F3DD3F197B5);
        add_vec("ecb_dec_ones", '1, 1'b1, 1'b0, 64'd0, 64'h5B791F3DD3F197B5,
                64'h5B791F3DD3F197B5, PT1);
`endif
        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef DES_CBC_MODE_EN
        // IV load and in_valid together: IV wins, block waits.
        @(negedge clk);
        iv_in        = 64'd0;
        iv_load      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = PT1;
        #1;
        chk("ivload_blocks_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("ivload_not_accepted", 64'(busy), 64'd0);
        iv_load      = 1'b0;
        bus.in_valid = 1'b0;
`endif

        // Back-pressure: result held stable for 5 cycles.
        load_iv(64'd0);
        send("bp", K1, 1'b0, PT1);
        wait_out("bp");
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_data_stable", bus.out_data, CT1);
            chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        end
        $display("block bp: held out=%h", held);
        ack();
        chk("bp_out_valid_cleared", 64'(bus.out_valid), 64'd0);

        // Done for the wrong direction is ignored.
        load_iv(64'd0);
        core_mode = 2;
        send("wrongdir", K1, 1'b0, PT1);
        n = 0;
        while (!core_done_decrypt && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wrongdir_seen", 64'(core_done_decrypt), 64'd1);
        @(negedge clk);
        chk("wrongdir_start_held", 64'(core_start_encrypt), 64'd1);
        wait_out("wrongdir");
        chk("wrongdir_out_data", bus.out_data, CT1);
        $display("block wrongdir: out=%h", bus.out_data);
        ack();
        core_mode = 0;

        // Watchdog: core never answers.
        load_iv(64'd0);
        core_mode = 1;
        ov0 = ov_cycles;
        send("timeout", K1, 1'b0, PT1);
        chk("timeout_not_early", 64'(timeout_err), 64'd0);
        n = 0;
        while (core_start_encrypt && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_start_cycles", 64'(n), 64'd32);
        chk("timeout_err_set", 64'(timeout_err), 64'd1);
        chk("timeout_starts_low", 64'({core_start_encrypt, core_start_decrypt}), 64'd0);
        n = 0;
        while (!bus.in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_in_ready_back", 64'(bus.in_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("timeout_no_out_valid", 64'(ov_cycles - ov0), 64'd0);
        chk("timeout_err_sticky", 64'(timeout_err), 64'd1);
        $display("block timeout: start held %0d cycles", n);

        // Reset in the middle of a block.
        send("midrst", K1, 1'b0, PT1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_starts", 64'({core_start_encrypt, core_start_decrypt}), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_timeout_clear", 64'(timeout_err), 64'd0);
        rst_n     = 1'b1;
        core_mode = 0;
        $display("block midrst: reset applied during run");

        // Normal operation resumes after reset.
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "bench time limit");
    end

endmodule
